// File: rtl/xalu_pkg.sv
// Shared XALU definitions: opcode encodings, default latencies, stall-logic predicate.
// Optional MADD/MSUB family is enabled by defining XALU_MADD_EN.
package xalu_pkg;

  typedef enum logic [3:0] {
    XALU_NONE  = 4'd0,
    XALU_MULT  = 4'd1,
    XALU_MULTU = 4'd2,
    XALU_DIV   = 4'd3,
    XALU_DIVU  = 4'd4,
    XALU_MFHI  = 4'd5,
    XALU_MFLO  = 4'd6,
    XALU_MTHI  = 4'd7,
    XALU_MTLO  = 4'd8,
    XALU_MADD  = 4'd9,
    XALU_MADDU = 4'd10,
    XALU_MSUB  = 4'd11,
    XALU_MSUBU = 4'd12
  } xaluOp_e;

  localparam int unsigned XALU_MULT_CYCLES_DEF = 5;
  localparam int unsigned XALU_DIV_CYCLES_DEF  = 10;

  // True for any op that touches HI/LO; decode stalls these while busy.
  function automatic logic usingXALU(input logic [3:0] op);
`ifdef XALU_MADD_EN
    return (op != XALU_NONE) && (op <= XALU_MSUBU);
`else
    return (op != XALU_NONE) && (op <= XALU_MTLO);
`endif
  endfunction

endpackage

// File: rtl/xalu_if.sv
// E-stage <-> XALU operation/result bundle.
interface xalu_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] out;

  modport master (output op, a, b, req, input busy, out);
  modport slave  (input op, a, b, req, output busy, out);
endinterface

// File: rtl/xalu_ctrl.sv
// Latency countdown for the XALU: holds busyR for the selected cycle count and
// pulses commit on the final busy edge.
module xalu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic busyR,
  output logic commit
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busyR  = (cnt != '0);
  assign commit = (cnt == CW'(1));

endmodule

// File: rtl/xalu.sv
// Execute-stage multiply/divide unit owning HI/LO; result computed at the start
// edge into pending registers and committed when the countdown expires.
// Define XALU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module xalu
  import xalu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = XALU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = XALU_DIV_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   reset,
  xalu_if.slave  bus
);

  logic [31:0] hi, lo, hiP, loP;
  logic        pendOk;
  logic        isMul, isDiv, isMt;
  logic        startValid, busyR, commit;
  logic [63:0] resP;
  logic [63:0] aS, bS, prodS, prodU;
  logic [31:0] quoS, remS, quoU, remU;

  assign aS    = {{32{bus.a[31]}}, bus.a};
  assign bS    = {{32{bus.b[31]}}, bus.b};
  assign prodS = aS * bS;
  assign prodU = {32'b0, bus.a} * {32'b0, bus.b};
  assign quoS  = $signed(bus.a) / $signed(bus.b);
  assign remS  = $signed(bus.a) % $signed(bus.b);
  assign quoU  = bus.a / bus.b;
  assign remU  = bus.a % bus.b;

  always_comb begin
    isMul = 1'b0;
    isDiv = 1'b0;
    isMt  = 1'b0;
    resP  = '0;
    case (bus.op)
      XALU_MULT:  begin isMul = 1'b1; resP = prodS; end
      XALU_MULTU: begin isMul = 1'b1; resP = prodU; end
      XALU_DIV:   begin isDiv = 1'b1; resP = {remS, quoS}; end
      XALU_DIVU:  begin isDiv = 1'b1; resP = {remU, quoU}; end
      XALU_MTHI,
      XALU_MTLO:  isMt = 1'b1;
`ifdef XALU_MADD_EN
      XALU_MADD:  begin isMul = 1'b1; resP = {hi, lo} + prodS; end
      XALU_MADDU: begin isMul = 1'b1; resP = {hi, lo} + prodU; end
      XALU_MSUB:  begin isMul = 1'b1; resP = {hi, lo} - prodS; end
      XALU_MSUBU: begin isMul = 1'b1; resP = {hi, lo} - prodU; end
`endif
      default: ;
    endcase
  end

  assign startValid = (isMul | isDiv) & ~bus.req & ~busyR;

  xalu_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) uCtrl (
    .clk   (clk),
    .reset (reset),
    .start (startValid),
    .isDiv (isDiv),
    .busyR (busyR),
    .commit(commit)
  );

  // A divide by zero still runs the full latency but its commit is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      hiP    <= '0;
      loP    <= '0;
      pendOk <= 1'b0;
    end else begin
      if (startValid) begin
        {hiP, loP} <= resP;
        pendOk     <= ~(isDiv & (bus.b == '0));
      end
      if (commit) begin
        if (pendOk) begin
          hi <= hiP;
          lo <= loP;
        end
      end else if (isMt && !bus.req && !busyR) begin
        if (bus.op == XALU_MTHI) hi <= bus.a;
        else                     lo <= bus.a;
      end
    end
  end

  assign bus.busy = reset & (startValid | busyR);

  always_comb begin
    bus.out = '0;
    if (reset) begin
      if (bus.op == XALU_MFHI)      bus.out = hi;
      else if (bus.op == XALU_MFLO) bus.out = lo;
    end
  end

endmodule

// File: tb/tb_xalu.sv
// Randomized self-checking bench for xalu against an arithmetic reference model.
module tb_xalu;
  import xalu_pkg::*;

`ifdef XALU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  xalu_if bus ();

  xalu #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] mHi, mLo;
  logic [63:0] mPend;
  bit          mPendOk;
  int          mRemain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit isStartOp(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD_EN && o >= 4'd9 && o <= 4'd12);
  endfunction

  function automatic logic [63:0] refResult(input logic [3:0] o, input logic [31:0] av, bv);
    int sa, sb, q, r;
    longint sp;
    longint unsigned ua, ub, up, acc;
    sa = av; sb = bv;
    ua = av; ub = bv;
    sp = longint'(sa) * longint'(sb);
    up = ua * ub;
    acc = {mHi, mLo};
    case (o)
      4'd1:  return sp;
      4'd2:  return up;
      4'd3:  begin
        if (bv == 0) return 64'd0;
        q = sa / sb; r = sa % sb;
        return {r, q};
      end
      4'd4:  return (bv == 0) ? 64'd0 : {av % bv, av / bv};
      4'd9:  return acc + sp;
      4'd10: return acc + up;
      4'd11: return acc - sp;
      4'd12: return acc - up;
      default: return 64'd0;
    endcase
  endfunction

  task automatic modelClear();
    mHi = '0; mLo = '0; mPend = '0; mPendOk = 0; mRemain = 0;
  endtask

  task automatic modelEdge(input logic [3:0] o, input logic [31:0] av, bv, input logic r);
    if (isStartOp(o) && !r && mRemain == 0) begin
      mPend   = refResult(o, av, bv);
      mPendOk = !((o == 4'd3 || o == 4'd4) && bv == 0);
      mRemain = (o == 4'd3 || o == 4'd4) ? DIV_LAT : MULT_LAT;
    end else if (mRemain > 0) begin
      if (mRemain == 1 && mPendOk) {mHi, mLo} = mPend;
      mRemain--;
    end else if (!r && o == 4'd7) begin
      mHi = av;
    end else if (!r && o == 4'd8) begin
      mLo = av;
    end
  endtask

  // One cycle: drive after negedge, check combinational outputs, advance model at posedge.
  task automatic cycle(input logic [3:0] o, input logic [31:0] av, bv, input logic r,
                       output logic busySeen, output logic [31:0] outSeen);
    bit expBusy;
    assert (!(mRemain > 0 && (isStartOp(o) || o == 4'd7 || o == 4'd8)))
      else $error("illegal XALU issue while busy");
    bus.op = o; bus.a = av; bus.b = bv; bus.req = r;
    #1;
    expBusy = (isStartOp(o) && !r && mRemain == 0) || (mRemain != 0);
    chk("busy", bus.busy, expBusy);
    chk("out", bus.out, (o == 4'd5) ? mHi : (o == 4'd6) ? mLo : 32'd0);
    busySeen = bus.busy;
    outSeen  = bus.out;
    @(posedge clk);
    modelEdge(o, av, bv, r);
    @(negedge clk);
  endtask

  task automatic runOp(input logic [3:0] o, input logic [31:0] av, bv, input logic r, input int expLen);
    logic bs;
    logic [31:0] os;
    int n;
    cycle(o, av, bv, r, bs, os);
    n = bs ? 1 : 0;
    for (int i = 0; i < 30 && bs; i++) begin
      cycle(XALU_MFHI, '0, '0, 1'b0, bs, os);
      if (bs) n++;
    end
    chk("busyLen", n, expLen);
  endtask

  task automatic expectHiLo(input logic [31:0] h, input logic [31:0] l);
    logic bs;
    logic [31:0] os;
    cycle(XALU_MFHI, '0, '0, 1'b0, bs, os);
    chk("hiConst", os, h);
    cycle(XALU_MFLO, '0, '0, 1'b0, bs, os);
    chk("loConst", os, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic bs;
    logic [31:0] os;
    logic [3:0]  o;
    logic [31:0] av, bv;
    logic        r;

    modelClear();
    reset = 1'b0;
    bus.op = XALU_NONE; bus.a = '0; bus.b = '0; bus.req = 1'b0;
    @(negedge clk);
    bus.op = XALU_MULT; bus.a = 32'd3; bus.b = 32'd4;
    #1 chk("rstBusy", bus.busy, 1'b0);
    bus.op = XALU_MFHI;
    #1 chk("rstOutHi", bus.out, 32'd0);
    bus.op = XALU_MFLO;
    #1 chk("rstOutLo", bus.out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.op = XALU_NONE;
    @(negedge clk);

    runOp(XALU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1 + MULT_LAT);
    expectHiLo(32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp(XALU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1 + MULT_LAT);
    expectHiLo(32'h00000001, 32'hFFFFFFFE);
    runOp(XALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1 + DIV_LAT);
    expectHiLo(32'hFFFFFFFF, 32'hFFFFFFFD);

    runOp(XALU_MTHI, 32'h12345678, '0, 1'b0, 0);
    runOp(XALU_DIV, 32'd5, 32'd0, 1'b0, 1 + DIV_LAT);
    expectHiLo(32'h12345678, 32'hFFFFFFFD);

    runOp(XALU_MULT, 32'd9, 32'd9, 1'b1, 0);
    runOp(XALU_MTLO, 32'hCAFEF00D, '0, 1'b1, 0);
    expectHiLo(32'h12345678, 32'hFFFFFFFD);

    // reset mid-divide: busy must drop at once and nothing commits later
    cycle(XALU_DIVU, 32'd100, 32'd7, 1'b0, bs, os);
    for (int i = 0; i < 3; i++) cycle(XALU_MFHI, '0, '0, 1'b0, bs, os);
    reset = 1'b0;
    bus.op = XALU_MFHI;
    #1 chk("midRstBusy", bus.busy, 1'b0);
    chk("midRstOut", bus.out, 32'd0);
    modelClear();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) cycle(XALU_MFLO, '0, '0, 1'b0, bs, os);
    expectHiLo(32'd0, 32'd0);

    runOp(XALU_MTHI, 32'd0, '0, 1'b0, 0);
    runOp(XALU_MTLO, 32'd10, '0, 1'b0, 0);
    runOp(XALU_MADD, 32'hFFFFFFFF, 32'd3, 1'b0, MADD_EN ? 1 + MULT_LAT : 0);
    expectHiLo(32'd0, MADD_EN ? 32'd7 : 32'd10);

    for (int i = 0; i < 800; i++) begin
      if (mRemain > 0) begin
        case ($urandom_range(0, 2))
          0: o = XALU_NONE;
          1: o = XALU_MFHI;
          default: o = XALU_MFLO;
        endcase
      end else begin
        o = 4'($urandom_range(0, 12));
      end
      av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      if ($urandom_range(0, 9) == 0) bv = '0;
      if (o == XALU_DIV && av == 32'h80000000 && bv == 32'hFFFFFFFF) bv = 32'd1;
      r = ($urandom_range(0, 7) == 0);
      cycle(o, av, bv, r, bs, os);
    end

    for (int i = 0; i < 12; i++) cycle(XALU_NONE, '0, '0, 1'b0, bs, os);
    expectHiLo(mHi, mLo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xalu.md
Name: xalu

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers; the direct upstream producer of the busy flag consumed by the decode-stage stall logic.
- Accepts one mult/div/move operation per cycle from the E-stage, runs mult/div as a fixed-latency multi-cycle operation and drives busy so D-stage mult/div-class instructions stall.
- Provides HI/LO read data to the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, cycles busy_r stays high after a MULT/MULTU (or MADD family) start cycle.
- DIV_CYCLES, 10, cycles busy_r stays high after a DIV/DIVU start cycle.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  4  E-stage XALU opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- req  input  1  exception/interrupt request this cycle; suppresses any state change caused by op.
- busy  output  1  start_valid OR busy_r; consumed by stall logic.
- out  output  32  HI for MFHI, LO for MFLO, else 0; combinational.

Behaviour:
- Reset (reset low, async): hi, lo, busy_r, cnt and the pending registers all clear to 0. busy and out are 0 while reset is held.
- start_valid = op in {1,2,3,4,9..12} AND !req AND !busy_r.
- On a start_valid edge:
  - Compute the result into hi_p/lo_p:
    - MULT/MULTU: 64-bit signed/unsigned product.
    - DIV/DIVU: lo_p = quotient, hi_p = remainder, truncating toward zero; remainder takes the sign of the dividend.
  - Load cnt with MULT_CYCLES or DIV_CYCLES. busy_r = (cnt != 0).
- Each edge with cnt > 1: cnt decrements. On the edge with cnt == 1: {hi,lo} <= {hi_p,lo_p} and cnt <= 0.
- Latency: busy is high for 1+MULT_CYCLES (6) or 1+DIV_CYCLES (11) consecutive cycles. An MFHI/MFLO in the first cycle after busy falls reads the new value.
- Divide by zero: the unit still goes busy for the full DIV_CYCLES, but hi/lo keep their old values. Any stale pending value is not committed.
- MTHI/MTLO (op 7/8, !req, !busy_r): hi or lo <= a at that edge. busy is not asserted.
- op of mult/div/MT class while busy_r is high: ignored with no state change. The stall logic prevents this case; the bench flags it as an assertion.
- req high: the current op has no effect (no start, no MT write). An in-flight operation is not aborted and completes normally, because its instruction has already committed.
- MFHI/MFLO never modify state. out reflects the architectural hi/lo, not the pending values.
- Simultaneous completion edge (cnt==1) and a new op: the new op cannot start (busy_r is high that cycle); the commit proceeds.

Optional Feature:
- XALU_MADD_EN defined: ops 9-12 are supported.
  - {hi,lo} result = {hi,lo} ± a*b, signed for MADD/MSUB and unsigned for MADDU/MSUBU, modulo 2^64.
  - The accumulate operand is the {hi,lo} at the start edge.
  - Latency is MULT_CYCLES.
- XALU_MADD_EN undefined: ops 9-12 are treated as NONE, with busy never raised and no state change.

Decomposition:
- Shared macros file holds:
  - XALU op encodings (`XALU_NONE` .. `XALU_MSUBU`).
  - MULT_CYCLES/DIV_CYCLES defaults.
  - The usingXALU predicate used by the stall logic.
- One natural sub-module, xalu_ctrl: cnt/busy_r countdown and commit strobe, parameterised by cycle count select. The arithmetic stays in xalu.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high 6 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFEB; out=HI on MFHI.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE; DIV a=0xFFFFFFF9 (-7), b=2 -> busy 11 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI a=0x12345678 then DIV a=5, b=0 -> busy 11 cycles; HI stays 0x12345678, LO unchanged.
- MULT with req=1 in the start cycle -> busy stays 0, HI/LO unchanged; MTLO with req=1 -> LO unchanged.
- DIVU started, reset pulsed low at cycle 4 of 11 -> busy drops immediately, HI=LO=0, no later commit.
- With XALU_MADD_EN: HI:LO=0:10, MADD a=0xFFFFFFFF (-1), b=3 -> HI:LO=0x00000000:0x00000007. Without the macro: same op -> busy 0, HI/LO unchanged.
